// File: rtl/spi_reg_arbiter.sv
// Arbitrates a 16x8 register bank between an edge-triggered SPI front end and a
// request/grant internal port, alternating ownership whenever both are waiting.
module spi_reg_arbiter #(
    parameter logic [15:0] RO_MASK = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_write,
    input  logic       spi_read,
    input  logic [3:0] spi_address,
    input  logic [7:0] spi_data_in,
    output logic [7:0] spi_data_out,
    input  logic       int_req,
    input  logic       int_we,
    input  logic [3:0] int_addr,
    input  logic [7:0] int_wdata,
    output logic       int_gnt,
    output logic       int_done,
    output logic [7:0] int_rdata,
    input  logic       int_clr_flags,
    output logic [7:0] state_indication
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SPI_RD  = 2'b01,
        SPI_WR  = 2'b10,
        INT_ACC = 2'b11
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] bank [16];

    logic       spi_write_d;
    logic       spi_read_d;
    logic       wr_edge;
    logic       rd_edge_raw;
    logic       rd_edge;
    logic       wr_pend;
    logic       rd_pend;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_addr;
    logic       overrun;
    logic       ro_err;
    logic       overrun_set;
    logic       ro_err_set;
    logic       last_owner;     // 0 = SPI, 1 = internal

    assign wr_edge     = spi_write & ~spi_write_d;
    assign rd_edge_raw = spi_read & ~spi_read_d;
    // A read edge coinciding with a write edge is dropped in favour of the write.
    assign rd_edge     = rd_edge_raw & ~wr_edge;

    assign overrun_set = (wr_edge & wr_pend) | (rd_edge & rd_pend) | (wr_edge & rd_edge_raw);
    assign ro_err_set  = (state == SPI_WR) && RO_MASK[wr_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        if (state == IDLE) begin
            if ((wr_pend || rd_pend) && (last_owner || !int_req)) begin
                next_state = wr_pend ? SPI_WR : SPI_RD;
            end else if (int_req && !int_done) begin
                next_state = INT_ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_write_d <= 1'b0;
            spi_read_d  <= 1'b0;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            overrun     <= 1'b0;
            ro_err      <= 1'b0;
            last_owner  <= 1'b0;
        end else begin
            spi_write_d <= spi_write;
            spi_read_d  <= spi_read;

            // A new edge wins over the service-cycle clear so it is never lost.
            if (wr_edge) begin
                wr_pend <= 1'b1;
            end else if (state == SPI_WR) begin
                wr_pend <= 1'b0;
            end

            if (rd_edge) begin
                rd_pend <= 1'b1;
            end else if (state == SPI_RD) begin
                rd_pend <= 1'b0;
            end

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (int_clr_flags) begin
                overrun <= 1'b0;
            end

            if (ro_err_set) begin
                ro_err <= 1'b1;
            end else if (int_clr_flags) begin
                ro_err <= 1'b0;
            end

            if (state == SPI_RD || state == SPI_WR) begin
                last_owner <= 1'b0;
            end else if (state == INT_ACC) begin
                last_owner <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_edge) begin
            wr_addr <= spi_address;
            wr_data <= spi_data_in;
        end
        if (rd_edge) begin
            rd_addr <= spi_address;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                bank[i] <= 8'h00;
            end
        end else if (state == SPI_WR && !RO_MASK[wr_addr]) begin
            bank[wr_addr] <= wr_data;
        end else if (state == INT_ACC && int_we) begin
            bank[int_addr] <= int_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_data_out     <= 8'h00;
            int_rdata        <= 8'h00;
            int_gnt          <= 1'b0;
            int_done         <= 1'b0;
            state_indication <= 8'h00;
        end else begin
            int_gnt          <= (next_state == INT_ACC);
            int_done         <= (state == INT_ACC);
            state_indication <= {overrun, ro_err, int_req, wr_pend | rd_pend, 2'b00, state};
            if (state == SPI_RD) begin
                spi_data_out <= bank[rd_addr];
            end
            if (state == INT_ACC && !int_we) begin
                int_rdata <= bank[int_addr];
            end
        end
    end

endmodule
